// File: rtl/sp_operand_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sp_pkg
// Purpose  : Shared definitions for the SP core operand collector and ALU:
//            opcode encodings, per-opcode source-operand mask, operand
//            selector encoding and the collector FSM state type.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package sp_pkg;

  // ALU opcode encodings. 4'hA..4'hF are pass-through opcodes with no sources.
  localparam logic [3:0] OP_CLEAR = 4'h0;
  localparam logic [3:0] OP_AB1   = 4'h1;
  localparam logic [3:0] OP_AB2   = 4'h2;
  localparam logic [3:0] OP_AB3   = 4'h3;
  localparam logic [3:0] OP_AB4   = 4'h4;
  localparam logic [3:0] OP_AB5   = 4'h5;
  localparam logic [3:0] OP_AB6   = 4'h6;
  localparam logic [3:0] OP_AB7   = 4'h7;
  localparam logic [3:0] OP_AB8   = 4'h8;
  localparam logic [3:0] OP_ABC   = 4'h9;

  // Source mask bits: bit0 = A, bit1 = B, bit2 = C.
  localparam logic [2:0] MASK_NONE = 3'b000;
  localparam logic [2:0] MASK_AB   = 3'b011;
  localparam logic [2:0] MASK_ABC  = 3'b111;
  localparam logic [2:0] MASK_B    = 3'b010;

  // Operand selector (the 2-bit operand pointer of the read sequencer).
  localparam logic [1:0] SEL_A = 2'd0;
  localparam logic [1:0] SEL_B = 2'd1;
  localparam logic [1:0] SEL_C = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Which register-file sources an opcode needs.
  function automatic logic [2:0] src_mask(input logic [3:0] op);
    if (op == OP_CLEAR) begin
      return MASK_NONE;
    end else if (op <= OP_AB8) begin
      return MASK_AB;
    end else if (op == OP_ABC) begin
      return MASK_ABC;
    end else begin
      return MASK_NONE;
    end
  endfunction

  // Lowest-numbered pending source; reads go out in A, B, C order.
  function automatic logic [1:0] first_src(input logic [2:0] m);
    if (m[0]) begin
      return SEL_A;
    end else if (m[1]) begin
      return SEL_B;
    end else begin
      return SEL_C;
    end
  endfunction

  // One-hot mask bit for an operand selector.
  function automatic logic [2:0] src_bit(input logic [1:0] s);
    return 3'b001 << s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sp_operand_collector_if.sv
`default_nettype none
// ============================================================================
// Module   : sp_operand_collector_if
// Purpose  : Bundles the operand collector's instruction input handshake,
//            register-file read port and ALU-side output handshake.
// Ports    : master - collector view (accepts instructions, drives RF reads
//                     and the operand output)
//            slave  - surrounding-pipeline view (decoder, RF, ALU stage)
// Revision : 1.0 - initial release
// ============================================================================
interface sp_operand_collector_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int OP_W   = 4
);

  // Instruction input
  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_op;
  logic [REG_AW-1:0] in_rd;
  logic [REG_AW-1:0] in_rs1;
  logic [REG_AW-1:0] in_rs2;
  logic [REG_AW-1:0] in_rs3;
  logic              in_imm_en;
  logic [DATA_W-1:0] in_imm;

  // Register-file read port (synchronous, one-cycle latency)
  logic              rf_rd_en;
  logic [REG_AW-1:0] rf_rd_addr;
  logic [DATA_W-1:0] rf_rd_data;

  // Operand output
  logic              out_valid;
  logic              out_ready;
  logic [OP_W-1:0]   out_alu_c;
  logic [DATA_W-1:0] out_a;
  logic [DATA_W-1:0] out_b;
  logic [DATA_W-1:0] out_c;
  logic [REG_AW-1:0] out_rd;

  modport master (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_rs3, in_imm_en, in_imm,
    input  rf_rd_data, out_ready,
    output in_ready, rf_rd_en, rf_rd_addr,
    output out_valid, out_alu_c, out_a, out_b, out_c, out_rd
  );

  modport slave (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_rs3, in_imm_en, in_imm,
    output rf_rd_data, out_ready,
    input  in_ready, rf_rd_en, rf_rd_addr,
    input  out_valid, out_alu_c, out_a, out_b, out_c, out_rd
  );

endinterface
`default_nettype wire

// File: rtl/sp_operand_collector.sv
`default_nettype none
// ============================================================================
// Module   : sp_operand_collector
// Purpose  : Accepts one decoded instruction, reads its source registers
//            one per cycle through the RF's synchronous read port, then
//            presents opcode and A/B/C operands to the ALU stage.
// Ports    : clock   - rising-edge clock
//            reset_n - synchronous active-low reset
//            bus     - sp_operand_collector_if.master (instruction in,
//                      RF read port, operand out)
// Revision : 1.0 - initial release
// ============================================================================
module sp_operand_collector
  import sp_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int OP_W   = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  sp_operand_collector_if.master bus
);

  state_t            state_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              rf_rd_en_q;
  logic [REG_AW-1:0] rf_rd_addr_q;

  logic [OP_W-1:0]   op_q;
  logic [REG_AW-1:0] rd_q;
  logic [REG_AW-1:0] rs1_q;
  logic [REG_AW-1:0] rs2_q;
  logic [REG_AW-1:0] rs3_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] c_q;

  // Read sequencer: sources still to issue, operand of the read on the port
  // this cycle, and the operand whose data arrives this cycle.
  logic [2:0]        remain_q;
  logic [1:0]        issue_sel_q;
  logic              pend_valid_q;
  logic [1:0]        pend_sel_q;

  logic [2:0]        op_mask_d;
  logic [2:0]        accept_mask_d;
  logic [2:0]        issue_mask_d;
  logic [1:0]        issue_sel_d;
  logic [2:0]        remain_d;
  logic [REG_AW-1:0] issue_addr_d;
  logic              accept_d;

  always_comb begin
    op_mask_d     = src_mask(bus.in_op);
    // An immediate replaces the B register read.
    accept_mask_d = bus.in_imm_en ? (op_mask_d & ~MASK_B) : op_mask_d;
    accept_d      = (state_q == ST_IDLE) && bus.in_valid && in_ready_q;

    // In IDLE the first read comes straight from the incoming instruction;
    // in FETCH the next read comes from what is still outstanding.
    issue_mask_d  = (state_q == ST_IDLE) ? accept_mask_d : remain_q;
    issue_sel_d   = first_src(issue_mask_d);
    remain_d      = issue_mask_d & ~src_bit(issue_sel_d);

    issue_addr_d  = '0;
    case (issue_sel_d)
      SEL_A:   issue_addr_d = (state_q == ST_IDLE) ? bus.in_rs1 : rs1_q;
      SEL_B:   issue_addr_d = (state_q == ST_IDLE) ? bus.in_rs2 : rs2_q;
      default: issue_addr_d = (state_q == ST_IDLE) ? bus.in_rs3 : rs3_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      rf_rd_en_q   <= 1'b0;
      rf_rd_addr_q <= '0;
      op_q         <= '0;
      rd_q         <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rs3_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      c_q          <= '0;
      remain_q     <= '0;
      issue_sel_q  <= SEL_A;
      pend_valid_q <= 1'b0;
      pend_sel_q   <= SEL_A;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_d) begin
            op_q         <= bus.in_op;
            rd_q         <= bus.in_rd;
            rs1_q        <= bus.in_rs1;
            rs2_q        <= bus.in_rs2;
            rs3_q        <= bus.in_rs3;
            a_q          <= '0;
            c_q          <= '0;
            // B carries the immediate only when the opcode uses B at all.
            b_q          <= (bus.in_imm_en && op_mask_d[1]) ? bus.in_imm : '0;
            in_ready_q   <= 1'b0;
            pend_valid_q <= 1'b0;
            if (accept_mask_d == MASK_NONE) begin
              state_q     <= ST_HOLD;
              out_valid_q <= 1'b1;
            end else begin
              state_q      <= ST_FETCH;
              rf_rd_en_q   <= 1'b1;
              rf_rd_addr_q <= issue_addr_d;
              issue_sel_q  <= issue_sel_d;
              remain_q     <= remain_d;
            end
          end
        end

        ST_FETCH: begin
          // Data for the read issued last cycle is on rf_rd_data now.
          if (pend_valid_q) begin
            case (pend_sel_q)
              SEL_A:   a_q <= bus.rf_rd_data;
              SEL_B:   b_q <= bus.rf_rd_data;
              default: c_q <= bus.rf_rd_data;
            endcase
          end
          pend_valid_q <= rf_rd_en_q;
          pend_sel_q   <= issue_sel_q;

          if (remain_q != MASK_NONE) begin
            rf_rd_en_q   <= 1'b1;
            rf_rd_addr_q <= issue_addr_d;
            issue_sel_q  <= issue_sel_d;
            remain_q     <= remain_d;
          end else begin
            rf_rd_en_q   <= 1'b0;
          end

          // Last capture: a pending read with nothing issued behind it.
          if (pend_valid_q && !rf_rd_en_q) begin
            state_q     <= ST_HOLD;
            out_valid_q <= 1'b1;
          end
        end

        ST_HOLD: begin
          if (bus.out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end

        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
          rf_rd_en_q  <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.rf_rd_en   = rf_rd_en_q;
  assign bus.rf_rd_addr = rf_rd_addr_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_alu_c  = op_q;
  assign bus.out_a      = a_q;
  assign bus.out_b      = b_q;
  assign bus.out_c      = c_q;
  assign bus.out_rd     = rd_q;

endmodule
`default_nettype wire

// File: tb/tb_sp_operand_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_sp_operand_collector
// Purpose  : Self-checking bench for sp_operand_collector with a register
//            file model, directed cases and randomized instructions.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_sp_operand_collector;

  logic clock;
  logic reset_n;
  int   checks;
  int   errors;
  logic [15:0] mem [16];

  sp_operand_collector_if #(.DATA_W(16), .REG_AW(4), .OP_W(4)) bus ();

  sp_operand_collector #(.DATA_W(16), .REG_AW(4), .OP_W(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Register file: synchronous read, data valid the cycle after rf_rd_en.
  always @(posedge clock) begin
    if (bus.rf_rd_en) bus.rf_rd_data <= mem[bus.rf_rd_addr];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_junk();
    bus.in_op     = 4'($urandom);
    bus.in_rd     = 4'($urandom);
    bus.in_rs1    = 4'($urandom);
    bus.in_rs2    = 4'($urandom);
    bus.in_rs3    = 4'($urandom);
    bus.in_imm_en = 1'($urandom);
    bus.in_imm    = 16'($urandom);
  endtask

  // Issue one instruction and check the whole transaction against the model.
  task automatic run_instr(input logic [3:0] op, input logic [3:0] rd,
                           input logic [3:0] rs1, input logic [3:0] rs2,
                           input logic [3:0] rs3, input logic imm_en,
                           input logic [15:0] imm, input int stall);
    logic [3:0]  exp_addr[$];
    logic [3:0]  got_addr[$];
    int          got_cyc[$];
    logic        alu, need_a, need_b, need_c, seen;
    logic [15:0] ea, eb, ec;
    int          n, exp_lat, cyc, waited;

    alu    = (op >= 4'd1) && (op <= 4'd9);
    need_a = alu;
    need_b = alu && !imm_en;
    need_c = (op == 4'd9);
    if (need_a) exp_addr.push_back(rs1);
    if (need_b) exp_addr.push_back(rs2);
    if (need_c) exp_addr.push_back(rs3);
    n       = exp_addr.size();
    exp_lat = (n == 0) ? 1 : n + 2;
    ea = need_a ? mem[rs1] : 16'h0;
    eb = alu ? (imm_en ? imm : mem[rs2]) : 16'h0;
    ec = need_c ? mem[rs3] : 16'h0;

    waited = 0;
    while (!bus.in_ready && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    check("in_ready_idle", bus.in_ready, 1);

    bus.in_valid  = 1'b1;
    bus.in_op     = op;
    bus.in_rd     = rd;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_rs3    = rs3;
    bus.in_imm_en = imm_en;
    bus.in_imm    = imm;
    bus.out_ready = (stall == 0);
    @(negedge clock);
    bus.in_valid = 1'b0;
    drive_junk();

    cyc  = 1;
    seen = 1'b0;
    while (cyc <= 12 && !seen) begin
      if (bus.rf_rd_en) begin
        got_addr.push_back(bus.rf_rd_addr);
        got_cyc.push_back(cyc);
      end
      check("in_ready_busy", bus.in_ready, 0);
      if (bus.out_valid) seen = 1'b1;
      else begin
        @(negedge clock);
        cyc++;
      end
    end
    check("out_valid_cycle", seen ? cyc : -1, exp_lat);
    check("read_count", got_addr.size(), n);
    for (int i = 0; i < n && i < got_addr.size(); i++) begin
      check("read_addr", got_addr[i], exp_addr[i]);
      check("read_cycle", got_cyc[i], i + 1);
    end
    check("out_a", bus.out_a, ea);
    check("out_b", bus.out_b, eb);
    check("out_c", bus.out_c, ec);
    check("out_alu_c", bus.out_alu_c, op);
    check("out_rd", bus.out_rd, rd);

    for (int i = 0; i < stall; i++) begin
      @(negedge clock);
      check("stall_valid", bus.out_valid, 1);
      check("stall_in_ready", bus.in_ready, 0);
      check("stall_rd_en", bus.rf_rd_en, 0);
      check("stall_outs", {bus.out_a, bus.out_b, bus.out_c, bus.out_alu_c, bus.out_rd},
            {ea, eb, ec, op, rd});
      if (n > 0) check("stall_rd_addr_hold", bus.rf_rd_addr, exp_addr[n-1]);
    end
    bus.out_ready = 1'b1;
    @(negedge clock);
    check("post_hs_valid", bus.out_valid, 0);
    check("post_hs_in_ready", bus.in_ready, 1);
  endtask

  initial begin
    logic [3:0] rop;
    logic       rimm;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
    mem[3] = 16'd25;
    mem[4] = 16'd2;
    mem[5] = 16'd5;
    bus.rf_rd_data = 16'h0;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b1;
    drive_junk();

    // Reset state
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_rd_en", bus.rf_rd_en, 0);
    check("rst_rd_addr", bus.rf_rd_addr, 0);
    check("rst_outs", {bus.out_a, bus.out_b, bus.out_c, bus.out_alu_c, bus.out_rd}, 0);
    reset_n = 1'b1;
    @(negedge clock);

    // Directed cases
    run_instr(4'h1, 4'd7, 4'd3, 4'd4, 4'd9, 1'b0, 16'h0000, 0);
    run_instr(4'h9, 4'd1, 4'd3, 4'd4, 4'd5, 1'b0, 16'h0000, 0);
    run_instr(4'h2, 4'd2, 4'd3, 4'd8, 4'd1, 1'b1, 16'h0007, 0);
    run_instr(4'h0, 4'd0, 4'd3, 4'd4, 4'd5, 1'b0, 16'h0000, 0);
    run_instr(4'hC, 4'd9, 4'd3, 4'd4, 4'd5, 1'b0, 16'h0000, 0);
    run_instr(4'h9, 4'd6, 4'd4, 4'd4, 4'd4, 1'b0, 16'h0000, 0);
    run_instr(4'h5, 4'd3, 4'd3, 4'd4, 4'd5, 1'b0, 16'h0000, 10);

    // Reset during cycle 2 of a three-read fetch
    bus.in_valid  = 1'b1;
    bus.in_op     = 4'h9;
    bus.in_rs1    = 4'd3;
    bus.in_rs2    = 4'd4;
    bus.in_rs3    = 4'd5;
    bus.in_imm_en = 1'b0;
    @(negedge clock);
    bus.in_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_rd_en", bus.rf_rd_en, 0);
    check("midrst_in_ready", bus.in_ready, 1);
    check("midrst_outs", {bus.out_a, bus.out_b, bus.out_c}, 0);
    reset_n = 1'b1;
    @(negedge clock);
    run_instr(4'h3, 4'd4, 4'd5, 4'd3, 4'd0, 1'b0, 16'h0000, 0);

    // Randomized instructions
    for (int k = 0; k < 40; k++) begin
      rop  = 4'($urandom);
      rimm = ((rop >= 4'd1) && (rop <= 4'd9)) ? 1'($urandom) : 1'b0;
      run_instr(rop, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                rimm, 16'($urandom), int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sp_operand_collector.md
# sp_operand_collector

Upstream stage of the SP core ALU. It accepts one decoded instruction at a time and reads the required source registers through the SP register file's single synchronous read port, one per cycle. It then presents the opcode and the A/B/C operands to the ALU stage through a valid/ready handshake. The ALU itself is combinational; this block supplies the sequencing around it.

## Interface
Parameters:
- DATA_W, 16, operand/register width (matches ALU A/B/C/ALU_OUT)
- REG_AW, 4, register index width (16 registers)
- OP_W, 4, ALU opcode width (ALU_C)

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset_n  in  1  reset: synchronous, active-low
- in_valid  in  1  decoded instruction available
- in_ready  out  1  collector can accept an instruction
- in_op  in  OP_W  ALU opcode
- in_rd  in  REG_AW  destination index, passed through
- in_rs1 / in_rs2 / in_rs3  in  REG_AW each  source indices for A / B / C
- in_imm_en  in  1  B is taken from in_imm, not the register file
- in_imm  in  DATA_W  immediate for B
- rf_rd_en  out  1  register-file read strobe
- rf_rd_addr  out  REG_AW  read index
- rf_rd_data  in  DATA_W  read data, valid the cycle after rf_rd_en
- out_valid  out  1  operands complete
- out_ready  in  1  ALU/writeback stage accepts
- out_alu_c  out  OP_W  opcode to ALU_C
- out_a / out_b / out_c  out  DATA_W each  operands
- out_rd  out  REG_AW  destination index

## Operation
- Source mask per opcode (bit0=A, bit1=B, bit2=C):
  - 4'h0 (CLEAR): none.
  - 4'h1–4'h8: A,B.
  - 4'h9: A,B,C.
  - 4'hA–4'hF: none; the opcode passes through unchanged.
- If in_imm_en=1, B is removed from the read mask and out_b = in_imm.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch op/rd/rs*/imm and compute the read list.
    - Empty list: go to HOLD.
    - Otherwise: go to FETCH.
  - FETCH: issue one read per cycle, in order A, B, C, skipping unneeded operands. Capture rf_rd_data one cycle after each issue into the matching operand register. After the last capture, go to HOLD.
  - HOLD: out_valid=1 and all out_* stable. On out_valid&&out_ready, go to IDLE.
- Unneeded operands are driven as 0. Identical source indices are still read separately; there is no read merging.
- No instruction overlap: in_ready=0 in FETCH and HOLD.
- Read issue and capture of the previous read occur in the same cycle; the read port is never idle mid-fetch.

## Timing
- Reset (reset_n=0 at a rising edge): state=IDLE, rf_rd_en=0, rf_rd_addr=0, out_valid=0, all out_* = 0. in_ready=1 from the first cycle after reset.
- Reset mid-FETCH or mid-HOLD: abort immediately. Pending read data is discarded and the latched instruction is lost.
- Acceptance at cycle 0, with n reads (n = 0..3):
  - Reads are issued in cycles 1..n.
  - out_valid rises in cycle n+2 for n≥1, and in cycle 1 for n=0.
- Minimum initiation interval: n+3 cycles for n≥1, and 2 cycles for n=0, with out_ready held high.
- in_ready returns to 1 the cycle after the output handshake. There is no same-cycle accept on the output-handshake cycle.
- out_ready low in HOLD: the block stalls indefinitely, outputs do not change and no reads are issued.
- rf_rd_en is asserted only in FETCH issue cycles. rf_rd_addr holds its last value when rf_rd_en=0.

## Structure
- Shared package sp_pkg holds:
  - the opcode localparams (OP_CLEAR=4'h0 … 4'h9);
  - the function src_mask(op) returning the 3-bit mask;
  - the FSM state enum {IDLE, FETCH, HOLD}.
- The ALU consumes sp_pkg as well, so opcode encodings stay in one place.
- No sub-module: one FSM plus the operand registers. The read sequencer is a 2-bit operand pointer with a pending-capture tag.

## Test plan
- After reset: in_ready=1, out_valid=0, all outputs 0.
- Op 4'h1, rs1=3 (R3=25), rs2=4 (R4=2), accepted at cycle 0:
  - reads addr 3 at cycle 1 and addr 4 at cycle 2;
  - out_valid at cycle 4 with out_a=25, out_b=2, out_c=0, out_alu_c=1.
- Op 4'h9, rs1/rs2/rs3 = 3/4/5 (R5=5), in_imm_en=0:
  - three reads in cycles 1–3;
  - out_valid at cycle 5 with a=25, b=2, c=5.
- Op 4'h2 with in_imm_en=1, in_imm=16'h0007, rs1=3:
  - a single read of addr 3;
  - out_valid at cycle 3 with b=7.
- Op 4'h0 (CLEAR): no rf_rd_en at all; out_valid at cycle 1 with all operands 0.
- Backpressure and reset:
  - With out_ready held low for 10 cycles, outputs stay stable and in_ready stays 0; on release, the handshake completes and in_ready=1 the next cycle.
  - reset_n=0 in cycle 2 of a 3-read fetch: the next cycle shows IDLE, out_valid=0 and rf_rd_en=0.
